// File: rtl/alu_issuer.sv
// Credit-based ALU command issuer and in-order response collector.
// Optional result checker (err_out) enabled by defining ALU_ISSUER_CHECK_EN.
module alu_issuer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_op,
  output logic [WIDTH-1:0] alu_a_out,
  output logic [WIDTH-1:0] alu_b_out,
  output logic             alu_op_out,
  output logic             alu_valid_out,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic             alu_valid_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_ISSUER_CHECK_EN
  output logic             err_out,
`endif
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             vld_q, vld_d;
  logic [CW-1:0]    infl_q, infl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic accept;
  logic ret;
  logic pop;

  // Credits count both in-flight ALU ops and queued responses.
  assign cmd_ready = ({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_C;
  assign accept    = cmd_valid & cmd_ready;
  assign ret       = alu_valid_in & (infl_q != '0);
  assign rsp_valid = cnt_q != '0;
  assign pop       = rsp_valid & rsp_ready;

  assign alu_a_out     = a_q;
  assign alu_b_out     = b_q;
  assign alu_op_out    = op_q;
  assign alu_valid_out = vld_q;
  assign rsp_data      = rsp_valid ? mem_q[rp_q] : '0;
  assign busy          = (infl_q != '0) | rsp_valid;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    vld_d  = accept;
    infl_d = infl_q;
    cnt_d  = cnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    mem_d  = mem_q;
    if (accept) begin
      a_d  = cmd_a;
      b_d  = cmd_b;
      op_d = cmd_op;
    end
    unique case ({accept, ret})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
    if (ret) begin
      mem_d[wp_q] = alu_result_in;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
    unique case ({ret, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      vld_q  <= 1'b0;
      infl_q <= '0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      vld_q  <= vld_d;
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      mem_q  <= mem_d;
    end
  end

`ifdef ALU_ISSUER_CHECK_EN
  // Expected-result queue occupancy always equals infl_q.
  logic [WIDTH-1:0] exp_q [DEPTH];
  logic [WIDTH-1:0] exp_d [DEPTH];
  logic [AW-1:0]    ewp_q, ewp_d;
  logic [AW-1:0]    erp_q, erp_d;
  logic             err_q, err_d;
  logic             stray;
  logic             miss;

  assign stray   = alu_valid_in & (infl_q == '0);
  assign miss    = ret & (exp_q[erp_q] != alu_result_in);
  assign err_out = err_q;

  always_comb begin
    exp_d = exp_q;
    ewp_d = ewp_q;
    erp_d = erp_q;
    err_d = err_q | stray | miss;
    if (accept) begin
      exp_d[ewp_q] = cmd_op ? cmd_b : cmd_a;
      ewp_d        = ewp_q + AW'(1);
    end
    if (ret) begin
      erp_d = erp_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ewp_q <= '0;
      erp_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_q[i] <= '0;
    end else begin
      ewp_q <= ewp_d;
      erp_q <= erp_d;
      err_q <= err_d;
      exp_q <= exp_d;
    end
  end
`endif

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator/collector on the far side of the ALU operand interface.
- Accepts operand commands over a valid/ready port and drives the ALU's a/b/op/valid inputs.
- Captures the ALU's result/valid return into a response FIFO and presents it over a valid/ready port.
- Uses credit-based issue so that no ALU result is ever dropped, since the ALU has no backpressure.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU's WIDTH.
- DEPTH, 4, response FIFO entries and maximum outstanding commands; power of two, >= 2.

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_op  in  1  0 selects A, 1 selects B
- alu_a_out  out  WIDTH  to ALU a_in
- alu_b_out  out  WIDTH  to ALU b_in
- alu_op_out  out  1  to ALU op_in
- alu_valid_out  out  1  to ALU valid_in
- alu_result_in  in  WIDTH  from ALU result_out
- alu_valid_in  in  1  from ALU valid_out
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  WIDTH  head of response FIFO (show-ahead)
- busy  out  1  inflight != 0 or FIFO non-empty

Behaviour:
- Reset values: alu_a_out=0, alu_b_out=0, alu_op_out=0, alu_valid_out=0, rsp_valid=0, rsp_data=0, busy=0. FIFO pointers, count and inflight are cleared.
- Reset is sampled on the clk edge and overrides all other activity in that cycle, including accept, ALU return and pop.
- Counters:
  - inflight (0..DEPTH): +1 on accept, -1 on a valid ALU return.
  - fifo_count (0..DEPTH): +1 on write, -1 on pop.
  - Simultaneous increment and decrement on the same counter: net 0.
- cmd_ready = (fifo_count + inflight) < DEPTH, decoded from registers only; no combinational path from cmd_valid.
- Issue:
  - An accept at edge N drives alu_valid_out=1 during cycle N+1, with alu_a/b/op_out holding the registered command.
  - Back-to-back accepts give a continuous alu_valid_out.
  - When there is no accept, alu_valid_out=0 and the operand outputs hold their last value.
- Return:
  - ALU latency is 1, so the result arrives as alu_valid_in during cycle N+2.
  - The result is written into the FIFO at the end of N+2 (inflight-1, fifo_count+1).
  - rsp_valid=1 and rsp_data=result during N+3.
- Ordering: responses are strictly in command order.
- Stray return (alu_valid_in while inflight==0): the data is not written and the counters are unchanged.
- Credit limit: with DEPTH outstanding, cmd_ready=0 until a pop frees a slot. cmd_ready rises the cycle after the pop edge.
- FIFO full: a write can never occur when full, because credits guarantee space.
- FIFO empty: a pop while empty is impossible because rsp_valid=0; rsp_ready is ignored.
- Simultaneous write and pop at fifo_count==DEPTH-1 or 1: handled as net 0, pointers wrap mod DEPTH.
- Reset mid-operation: in-flight commands are discarded. ALU returns arriving after reset are treated as stray, since the ALU shares the reset.

Optional Feature:
- Macro: ALU_ISSUER_CHECK_EN.
- When defined:
  - Adds output err_out (1 bit) and an expected-value queue of DEPTH entries.
  - On accept, the queue pushes cmd_op ? cmd_b : cmd_a.
  - On each valid return, the queue pops and the entry is compared with alu_result_in.
  - A mismatch or a stray return sets err_out=1 on the following cycle. err_out is sticky until reset; its reset value is 0.
- When undefined: no err_out port and no checking logic; behaviour is otherwise identical.

Test Plan:
- Single command: a=4'h3, b=4'hA, op=0, accept at edge 0 -> alu_valid_out=1 in cycle 1 with a=3, b=A, op=0. With a model ALU, rsp_valid=1 and rsp_data=4'h3 in cycle 3. Pop -> busy=0 next cycle.
- Back-to-back: 4 commands (op=1, b=1,2,3,4), rsp_ready=0 -> 4 consecutive alu_valid_out pulses, then cmd_ready=0. FIFO holds 1,2,3,4. One pop -> cmd_ready=1 the next cycle.
- Streaming: cmd_valid=1 and rsp_ready=1 continuously, DEPTH=4 -> a sustained 1 command/cycle. No loss, in-order data, cmd_ready never drops.
- Stray return: alu_valid_in=1 with inflight=0 -> rsp_valid stays 0, counters unchanged. With ALU_ISSUER_CHECK_EN, err_out=1 the next cycle.
- Mismatch: cmd a=5, op=0, bench ALU returns 6 -> rsp_data=6 is still delivered. With ALU_ISSUER_CHECK_EN, err_out=1 and stays set until reset.
- Reset mid-operation: reset=1 for 1 cycle with 2 in flight and 1 queued -> all outputs at reset values the next cycle, cmd_ready=1, busy=0. Late ALU returns are not written.
